car_motion_scheduler: RTL

//  Collective (SCAN) scheduler for one 2-way, 7-floor car. Latches hall and car calls
//  and selects the serving direction. Times floor-to-floor travel, decides where to stop,
//  and drives the door controller: moving acts as door reset, plus current floor/direction.

---
 rtl/car_motion_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/car_motion_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : car_motion_scheduler
//  Description : Collective (SCAN) scheduler for a single 7-floor car.
//                Latches hall/car calls, chooses the serving direction,
//                times floor-to-floor travel, decides where to stop and
//                hands the car to the door controller.
//  Ports       : clk, reset (sync, active-high), i_enable (0 = freeze),
//                i_hall_up_btn/i_hall_dn_btn/i_car_btn (bit n = floor n+1),
//                i_door_state (1 = door open),
//                o_current_floor (1..7), o_current_dir (UP=10, DOWN=01,
//                STOP=00), o_moving (door controller reset),
//                o_up_pending/o_dn_pending/o_car_pending (latched calls)
//  Revision    : 1.0  initial release
// ============================================================================
module car_motion_scheduler #(
    parameter int CLK_PER_FLOOR = 100000000,
    parameter int DOOR_TIMEOUT  = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [6:0] i_hall_up_btn,
    input  logic [6:0] i_hall_dn_btn,
    input  logic [6:0] i_car_btn,
    input  logic       i_door_state,
    output logic [2:0] o_current_floor,
    output logic [1:0] o_current_dir,
    output logic       o_moving,
    output logic [6:0] o_up_pending,
    output logic [6:0] o_dn_pending,
    output logic [6:0] o_car_pending
);

    localparam int              c_cnt_w     = $clog2(CLK_PER_FLOOR);
    localparam int              c_door_w    = $clog2(DOOR_TIMEOUT);
    localparam logic [c_cnt_w-1:0]  c_cnt_load = c_cnt_w'(CLK_PER_FLOOR - 1);
    localparam logic [c_door_w-1:0] c_door_last = c_door_w'(DOOR_TIMEOUT - 1);
    localparam logic [1:0]      c_dir_stop  = 2'b00;
    localparam logic [1:0]      c_dir_up    = 2'b10;
    localparam logic [1:0]      c_dir_dn    = 2'b01;
    // No up call exists at the top floor, no down call at the bottom floor.
    localparam logic [6:0]      c_up_valid  = 7'b0111111;
    localparam logic [6:0]      c_dn_valid  = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t                r_state, w_state_nx;
    logic [2:0]            r_floor, w_floor_nx;
    logic [1:0]            r_dir,   w_dir_nx;
    logic [c_cnt_w-1:0]    r_cnt,   w_cnt_nx;
    logic [c_door_w-1:0]   r_dcnt,  w_dcnt_nx;
    logic                  r_seen,  w_seen_nx;
    logic [6:0]            r_up, r_dn, r_car;
    logic [6:0]            w_clr_up, w_clr_dn, w_clr_car;

    logic [6:0]            w_all, w_here, w_arr_here;
    logic [2:0]            w_arr_floor;
    logic                  w_ahead_up, w_ahead_dn, w_ahead_cur;
    logic                  w_arr_ahead, w_arr_hall_dir, w_arr_hall_opp, w_arr_stop;

    // One-hot mask of the given floor.
    function automatic logic [6:0] floor_mask(input logic [2:0] f);
        logic [6:0] m;
        for (int i = 0; i < 7; i++) m[i] = (3'(i + 1) == f);
        return m;
    endfunction

    // Floors strictly beyond f in the given direction (up=1 / down=0).
    function automatic logic [6:0] beyond_mask(input logic [2:0] f, input logic up);
        logic [6:0] m;
        for (int i = 0; i < 7; i++) m[i] = up ? (3'(i + 1) > f) : (3'(i + 1) < f);
        return m;
    endfunction

    // Call bookkeeping at the current floor and at the floor being reached.
    always_comb begin
        w_all       = r_up | r_dn | r_car;
        w_here      = floor_mask(r_floor);
        w_ahead_up  = |(w_all & beyond_mask(r_floor, 1'b1));
        w_ahead_dn  = |(w_all & beyond_mask(r_floor, 1'b0));
        w_ahead_cur = ((r_dir == c_dir_up) && w_ahead_up) ||
                      ((r_dir == c_dir_dn) && w_ahead_dn);

        // Saturate at the end floors so the car can never leave 1..7.
        w_arr_floor = r_floor;
        if (r_dir == c_dir_up && r_floor != 3'd7)
            w_arr_floor = r_floor + 3'd1;
        else if (r_dir == c_dir_dn && r_floor != 3'd1)
            w_arr_floor = r_floor - 3'd1;

        w_arr_here     = floor_mask(w_arr_floor);
        w_arr_ahead    = |(w_all & beyond_mask(w_arr_floor, r_dir == c_dir_up));
        w_arr_hall_dir = (r_dir == c_dir_up) ? |(r_up & w_arr_here) : |(r_dn & w_arr_here);
        w_arr_hall_opp = (r_dir == c_dir_up) ? |(r_dn & w_arr_here) : |(r_up & w_arr_here);
        w_arr_stop     = |(r_car & w_arr_here) || w_arr_hall_dir || !w_arr_ahead;
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        w_floor_nx = r_floor;
        w_dir_nx   = r_dir;
        w_cnt_nx   = r_cnt;
        w_dcnt_nx  = r_dcnt;
        w_seen_nx  = r_seen;
        w_clr_up   = '0;
        w_clr_dn   = '0;
        w_clr_car  = '0;

        case (r_state)
            S_IDLE: begin
                if (w_ahead_cur) begin
                    w_state_nx = S_MOVE;
                    w_cnt_nx   = c_cnt_load;
                end else if (w_ahead_up) begin
                    w_dir_nx   = c_dir_up;
                    w_state_nx = S_MOVE;
                    w_cnt_nx   = c_cnt_load;
                end else if (w_ahead_dn) begin
                    w_dir_nx   = c_dir_dn;
                    w_state_nx = S_MOVE;
                    w_cnt_nx   = c_cnt_load;
                end else if (|(w_all & w_here)) begin
                    // Door must never open with STOP: a lone car call picks UP.
                    if (|(r_up & w_here))      w_dir_nx = c_dir_up;
                    else if (|(r_dn & w_here)) w_dir_nx = c_dir_dn;
                    else                       w_dir_nx = c_dir_up;
                    w_state_nx = S_DOOR;
                    w_dcnt_nx  = '0;
                    w_seen_nx  = 1'b0;
                    w_clr_car  = w_here;
                    if (w_dir_nx == c_dir_up) w_clr_up = w_here;
                    else                      w_clr_dn = w_here;
                end else begin
                    w_dir_nx = c_dir_stop;
                    w_clr_up = w_here;
                    w_clr_dn = w_here;
                end
            end

            S_MOVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_floor_nx = w_arr_floor;
                    if (!w_arr_ahead && w_arr_hall_opp)
                        w_dir_nx = {r_dir[0], r_dir[1]};
                    if (w_arr_stop) begin
                        w_state_nx = S_DOOR;
                        w_dcnt_nx  = '0;
                        w_seen_nx  = 1'b0;
                        w_clr_car  = w_arr_here;
                        if (w_dir_nx == c_dir_up) w_clr_up = w_arr_here;
                        else                      w_clr_dn = w_arr_here;
                    end else begin
                        w_cnt_nx = c_cnt_load;
                    end
                end
            end

            S_DOOR: begin
                // Calls at this floor in the serving direction are absorbed
                // by the open door rather than causing a second stop.
                w_clr_car = w_here;
                if (r_dir == c_dir_up) w_clr_up = w_here;
                else                   w_clr_dn = w_here;
                w_seen_nx = r_seen | i_door_state;
                w_dcnt_nx = r_dcnt + 1'b1;
                if ((r_seen && !i_door_state) || (r_dcnt == c_door_last))
                    w_state_nx = S_IDLE;
            end

            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_floor <= 3'd1;
            r_dir   <= c_dir_stop;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_seen  <= 1'b0;
            r_up    <= '0;
            r_dn    <= '0;
            r_car   <= '0;
        end else if (i_enable) begin
            r_state <= w_state_nx;
            r_floor <= w_floor_nx;
            r_dir   <= w_dir_nx;
            r_cnt   <= w_cnt_nx;
            r_dcnt  <= w_dcnt_nx;
            r_seen  <= w_seen_nx;
            // A press in the same cycle as a clear wins.
            r_up    <= (r_up  & ~w_clr_up)  | (i_hall_up_btn & c_up_valid);
            r_dn    <= (r_dn  & ~w_clr_dn)  | (i_hall_dn_btn & c_dn_valid);
            r_car   <= (r_car & ~w_clr_car) | i_car_btn;
        end
    end

    assign o_current_floor = r_floor;
    assign o_current_dir   = r_dir;
    assign o_moving        = (r_state == S_MOVE);
    assign o_up_pending    = r_up;
    assign o_dn_pending    = r_dn;
    assign o_car_pending   = r_car;

endmodule
`default_nettype wire
